// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register feeding the 16-bit ALU.
// Holds the decoded operand set, forwards from EX/MEM and MEM/WB, and supports stall and flush.
module ex_operand_stage #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDX   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [2:0]       id_op,
    input  logic             id_inv_a,
    input  logic             id_inv_b,
    input  logic             id_cin,
    input  logic             id_sign,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic [IDX-1:0]   id_rs_idx,
    input  logic [IDX-1:0]   id_rt_idx,
    input  logic [IDX-1:0]   id_rd_idx,
    input  logic [WIDTH-1:0] id_imm,
    input  logic             id_use_imm,
    input  logic             id_wr_en,
    input  logic             exmem_wr_en,
    input  logic [IDX-1:0]   exmem_rd,
    input  logic [WIDTH-1:0] exmem_data,
    input  logic             memwb_wr_en,
    input  logic [IDX-1:0]   memwb_rd,
    input  logic [WIDTH-1:0] memwb_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    output logic             alu_inv_a,
    output logic             alu_inv_b,
    output logic             alu_cin,
    output logic             alu_sign,
    output logic             ex_valid,
    output logic [IDX-1:0]   ex_rd,
    output logic             ex_wr_en
);

    logic             valid_q;
    logic             wr_en_q;
    logic [2:0]       op_q;
    logic             inv_a_q;
    logic             inv_b_q;
    logic             cin_q;
    logic             sign_q;
    logic [IDX-1:0]   rs_idx_q;
    logic [IDX-1:0]   rt_idx_q;
    logic [IDX-1:0]   rd_idx_q;
    logic [WIDTH-1:0] rs_data_q;
    logic [WIDTH-1:0] rt_data_q;
    logic [WIDTH-1:0] imm_q;
    logic             use_imm_q;

    logic [WIDTH-1:0] fwd_rs;
    logic [WIDTH-1:0] fwd_rt;

    // EX/MEM is the younger producer, so it is tested last and wins on a double match.
    always_comb begin
        fwd_rs = rs_data_q;
        if (memwb_wr_en && (memwb_rd == rs_idx_q)) fwd_rs = memwb_data;
        if (exmem_wr_en && (exmem_rd == rs_idx_q)) fwd_rs = exmem_data;

        fwd_rt = rt_data_q;
        if (memwb_wr_en && (memwb_rd == rt_idx_q)) fwd_rt = memwb_data;
        if (exmem_wr_en && (exmem_rd == rt_idx_q)) fwd_rt = exmem_data;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            op_q      <= '0;
            inv_a_q   <= 1'b0;
            inv_b_q   <= 1'b0;
            cin_q     <= 1'b0;
            sign_q    <= 1'b0;
            rs_idx_q  <= '0;
            rt_idx_q  <= '0;
            rd_idx_q  <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            use_imm_q <= 1'b0;
        end else if (stall) begin
            // Refresh operands so a producer retiring during the stall is not lost.
            rs_data_q <= fwd_rs;
            rt_data_q <= fwd_rt;
        end else begin
            valid_q   <= id_valid;
            wr_en_q   <= id_wr_en;
            op_q      <= id_op;
            inv_a_q   <= id_inv_a;
            inv_b_q   <= id_inv_b;
            cin_q     <= id_cin;
            sign_q    <= id_sign;
            rs_idx_q  <= id_rs_idx;
            rt_idx_q  <= id_rt_idx;
            rd_idx_q  <= id_rd_idx;
            rs_data_q <= id_rs_data;
            rt_data_q <= id_rt_data;
            imm_q     <= id_imm;
            use_imm_q <= id_use_imm;
        end
    end

    always_comb begin
        alu_a     = fwd_rs;
        alu_b     = use_imm_q ? imm_q : fwd_rt;
        alu_op    = op_q;
        alu_inv_a = inv_a_q;
        alu_inv_b = inv_b_q;
        alu_cin   = cin_q;
        alu_sign  = sign_q;
        ex_valid  = valid_q;
        ex_rd     = rd_idx_q;
        ex_wr_en  = valid_q & wr_en_q;
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: table of load/forward vectors plus stall, flush and reset sequences,
// with expected outputs queued at drive time and popped when the outputs are sampled.
module tb_ex_operand_stage;
    localparam int W = 16;
    localparam int I = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b0, stall = 1'b0, flush = 1'b0;
    logic         id_valid = 1'b0, id_inv_a = 1'b0, id_inv_b = 1'b0, id_cin = 1'b0;
    logic         id_sign = 1'b0, id_use_imm = 1'b0, id_wr_en = 1'b0;
    logic [2:0]   id_op = '0;
    logic [W-1:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0;
    logic [I-1:0] id_rs_idx = '0, id_rt_idx = '0, id_rd_idx = '0;
    logic         exmem_wr_en = 1'b0, memwb_wr_en = 1'b0;
    logic [I-1:0] exmem_rd = '0, memwb_rd = '0;
    logic [W-1:0] exmem_data = '0, memwb_data = '0;
    logic [W-1:0] alu_a, alu_b;
    logic [2:0]   alu_op;
    logic         alu_inv_a, alu_inv_b, alu_cin, alu_sign, ex_valid, ex_wr_en;
    logic [I-1:0] ex_rd;

    ex_operand_stage #(.WIDTH(W), .IDX(I)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_op(id_op), .id_inv_a(id_inv_a), .id_inv_b(id_inv_b),
        .id_cin(id_cin), .id_sign(id_sign), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_rs_idx(id_rs_idx), .id_rt_idx(id_rt_idx), .id_rd_idx(id_rd_idx), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_wr_en(id_wr_en),
        .exmem_wr_en(exmem_wr_en), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
        .memwb_wr_en(memwb_wr_en), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_inv_a(alu_inv_a),
        .alu_inv_b(alu_inv_b), .alu_cin(alu_cin), .alu_sign(alu_sign),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_wr_en(ex_wr_en)
    );

    typedef struct packed {
        logic         valid, wr_en, use_imm, inv_a, inv_b, cin, sign;
        logic [2:0]   op;
        logic [I-1:0] rs_idx, rt_idx, rd_idx;
        logic [W-1:0] rs_data, rt_data, imm;
        logic         xw;
        logic [I-1:0] xrd;
        logic [W-1:0] xd;
        logic         mw;
        logic [I-1:0] mrd;
        logic [W-1:0] md;
        logic [W-1:0] exp_a, exp_b;
        logic         exp_wr;
    } vec_t;

    typedef struct packed {
        logic [W-1:0] a, b;
        logic [2:0]   op;
        logic [3:0]   ctl;
        logic         valid;
        logic [I-1:0] rd;
        logic         wr;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    vec_t vecs[8];

    task automatic cmp(input string tag, input string f, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", tag, f, act, exp);
        end
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got nothing to compare", tag);
            return;
        end
        e = sb.pop_front();
        cmp(tag, "alu_a", alu_a, e.a);
        cmp(tag, "alu_b", alu_b, e.b);
        cmp(tag, "alu_op", W'(alu_op), W'(e.op));
        cmp(tag, "ctl", W'({alu_inv_a, alu_inv_b, alu_cin, alu_sign}), W'(e.ctl));
        cmp(tag, "ex_valid", W'(ex_valid), W'(e.valid));
        cmp(tag, "ex_rd", W'(ex_rd), W'(e.rd));
        cmp(tag, "ex_wr_en", W'(ex_wr_en), W'(e.wr));
    endtask

    task automatic fwd_off();
        exmem_wr_en = 1'b0; exmem_rd = '0; exmem_data = '0;
        memwb_wr_en = 1'b0; memwb_rd = '0; memwb_data = '0;
    endtask

    task automatic drive_id(input vec_t v);
        id_valid = v.valid; id_wr_en = v.wr_en; id_use_imm = v.use_imm;
        id_inv_a = v.inv_a; id_inv_b = v.inv_b; id_cin = v.cin; id_sign = v.sign;
        id_op = v.op; id_rs_idx = v.rs_idx; id_rt_idx = v.rt_idx; id_rd_idx = v.rd_idx;
        id_rs_data = v.rs_data; id_rt_data = v.rt_data; id_imm = v.imm;
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        exp_t e;
        @(negedge clk);
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        drive_id(v);
        fwd_off();
        e = '{a: v.exp_a, b: v.exp_b, op: v.op, ctl: {v.inv_a, v.inv_b, v.cin, v.sign},
              valid: v.valid, rd: v.rd_idx, wr: v.exp_wr};
        sb.push_back(e);
        @(posedge clk);
        #1;
        exmem_wr_en = v.xw; exmem_rd = v.xrd; exmem_data = v.xd;
        memwb_wr_en = v.mw; memwb_rd = v.mrd; memwb_data = v.md;
        #1;
        check_out(tag);
    endtask

    vec_t   v;
    exp_t   e;

    initial begin
        // plain ADD, no forwarding
        vecs[0] = '{valid: 1, wr_en: 1, op: 3'd4, rs_idx: 1, rt_idx: 2, rd_idx: 3,
                    rs_data: 16'h0123, rt_data: 16'h0234, exp_a: 16'h0123, exp_b: 16'h0234,
                    exp_wr: 1, default: 0};
        // both stages match rs: EX/MEM wins
        vecs[1] = '{valid: 1, wr_en: 1, op: 3'd5, rs_idx: 2, rt_idx: 4, rd_idx: 1,
                    rs_data: 16'h1111, rt_data: 16'h4444, xw: 1, xrd: 2, xd: 16'hAAAA,
                    mw: 1, mrd: 2, md: 16'h5555, exp_a: 16'hAAAA, exp_b: 16'h4444,
                    exp_wr: 1, default: 0};
        // EX/MEM disabled: MEM/WB supplies rs
        vecs[2] = '{valid: 1, wr_en: 1, op: 3'd5, rs_idx: 2, rt_idx: 4, rd_idx: 1,
                    rs_data: 16'h1111, rt_data: 16'h4444, xw: 0, xrd: 2, xd: 16'hAAAA,
                    mw: 1, mrd: 2, md: 16'h5555, exp_a: 16'h5555, exp_b: 16'h4444,
                    exp_wr: 1, default: 0};
        // immediate B is never forwarded
        vecs[3] = '{valid: 1, wr_en: 1, use_imm: 1, op: 3'd1, rs_idx: 5, rt_idx: 3, rd_idx: 6,
                    rs_data: 16'h5050, rt_data: 16'h3333, imm: 16'h0008, xw: 1, xrd: 3,
                    xd: 16'hFFFF, exp_a: 16'h5050, exp_b: 16'h0008, exp_wr: 1, default: 0};
        // MEM/WB forwards rt; EX/MEM targets another register
        vecs[4] = '{valid: 1, wr_en: 0, op: 3'd6, inv_b: 1, cin: 1, rs_idx: 0, rt_idx: 6,
                    rd_idx: 2, rs_data: 16'h0F00, rt_data: 16'h0606, xw: 1, xrd: 7,
                    xd: 16'h7777, mw: 1, mrd: 6, md: 16'hBEEF, exp_a: 16'h0F00,
                    exp_b: 16'hBEEF, exp_wr: 0, default: 0};
        // invalid slot: wr_en suppressed, forwarding still applied
        vecs[5] = '{valid: 0, wr_en: 1, op: 3'd3, inv_a: 1, sign: 1, rs_idx: 0, rt_idx: 1,
                    rd_idx: 5, rs_data: 16'h1000, rt_data: 16'h2000, xw: 1, xrd: 0,
                    xd: 16'h0F0F, exp_a: 16'h0F0F, exp_b: 16'h2000, exp_wr: 0, default: 0};
        // EX/MEM matches index but is not writing; MEM/WB has another index
        vecs[6] = '{valid: 1, wr_en: 1, op: 3'd7, inv_a: 1, inv_b: 1, cin: 1, sign: 1,
                    rs_idx: 7, rt_idx: 7, rd_idx: 7, rs_data: 16'hC0DE, rt_data: 16'hFACE,
                    xw: 0, xrd: 7, xd: 16'h1111, mw: 1, mrd: 4, md: 16'h2222,
                    exp_a: 16'hC0DE, exp_b: 16'hFACE, exp_wr: 1, default: 0};
        // both operands from EX/MEM on same index
        vecs[7] = '{valid: 1, wr_en: 1, op: 3'd2, rs_idx: 4, rt_idx: 4, rd_idx: 0,
                    rs_data: 16'h0001, rt_data: 16'h0002, xw: 1, xrd: 4, xd: 16'h8001,
                    mw: 1, mrd: 4, md: 16'h9999, exp_a: 16'h8001, exp_b: 16'h8001,
                    exp_wr: 1, default: 0};

        // reset with a valid instruction presented
        @(negedge clk);
        rst = 1'b1; stall = 1'b1; flush = 1'b0;
        v = vecs[6];
        drive_id(v);
        fwd_off();
        repeat (2) @(posedge clk);
        #1;
        sb.push_back('0);
        check_out("reset");

        for (int k = 0; k < 8; k++) apply_vec(vecs[k], $sformatf("vec%0d", k));

        // stall: rs refreshed from MEM/WB while held, then survives the producer leaving
        v = '{valid: 1, wr_en: 1, op: 3'd4, rs_idx: 1, rt_idx: 2, rd_idx: 3,
              rs_data: 16'h0001, rt_data: 16'h0222, default: 0};
        @(negedge clk);
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        drive_id(v);
        fwd_off();
        @(negedge clk);
        stall = 1'b1;
        id_rs_data = 16'h9999; id_op = 3'd7; id_rs_idx = 3'd5; id_valid = 1'b0;
        memwb_wr_en = 1'b1; memwb_rd = 3'd1; memwb_data = 16'h1234;
        #1;
        e = '{a: 16'h1234, b: 16'h0222, op: 3'd4, ctl: 4'd0, valid: 1, rd: 3'd3, wr: 1};
        sb.push_back(e);
        check_out("stall_fwd");
        @(posedge clk);
        #1;
        memwb_wr_en = 1'b0;
        stall = 1'b0;
        #1;
        sb.push_back(e);
        check_out("stall_refresh");

        // flush during stall inserts a bubble
        v = '{valid: 1, wr_en: 1, op: 3'd5, inv_a: 1, cin: 1, rs_idx: 2, rt_idx: 3, rd_idx: 4,
              rs_data: 16'h5A5A, rt_data: 16'hA5A5, default: 0};
        @(negedge clk);
        drive_id(v);
        fwd_off();
        @(negedge clk);
        stall = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('0);
        check_out("flush_in_stall");

        @(negedge clk);
        stall = 1'b0;
        flush = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
ID/EX pipeline register directly upstream of the 16-bit ALU. Captures decoded operands and ALU controls (op, invA, invB, cin, sign) each cycle. Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages. Supports stall (hold) and flush (bubble insertion) so the ALU always sees a coherent operand set.

Parameters:
WIDTH, 16, datapath width; equals ALU operand width.
IDX, 3, register index width (8 GPRs; R0 is an ordinary register, not hardwired).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
stall  input  1  hold current contents.
flush  input  1  replace next contents with a bubble.
id_valid  input  1  decode slot holds a real instruction.
id_op  input  3  ALU op code: ROL=0, SLL=1, ROR=2, SRA=3, ADD=4, OR=5, XOR=6, AND=7.
id_inv_a, id_inv_b, id_cin, id_sign  input  1 each  ALU controls.
id_rs_data, id_rt_data  input  WIDTH  register-file read data.
id_rs_idx, id_rt_idx, id_rd_idx  input  IDX  source and destination indices.
id_imm  input  WIDTH  sign/zero-extended immediate from decode.
id_use_imm  input  1  B operand comes from id_imm, not rt.
id_wr_en  input  1  instruction writes rd.
exmem_wr_en  input  1  EX/MEM result valid for forwarding.
exmem_rd  input  IDX  EX/MEM destination index.
exmem_data  input  WIDTH  EX/MEM result.
memwb_wr_en, memwb_rd, memwb_data  input  1/IDX/WIDTH  same, from MEM/WB.
alu_a, alu_b  output  WIDTH  forwarded operands to ALU.
alu_op  output  3  to ALU.
alu_inv_a, alu_inv_b, alu_cin, alu_sign  output  1 each  to ALU.
ex_valid  output  1  EX slot holds a real instruction.
ex_rd  output  IDX  destination index carried forward.
ex_wr_en  output  1  ex_valid AND held wr_en.

Behaviour:
- Reset (rst=1 at a clock edge): all held state cleared to 0: valid, wr_en, op, controls, indices, operands, use_imm. rst overrides stall and flush.
- Priority at each edge: rst > flush > stall > load.
- Load (no rst/flush/stall): all id_* captured; 1-cycle latency from decode to ALU inputs.
- Flush: held state becomes a bubble. valid=0, wr_en=0, op=0, controls=0, operands=0. A flush during a stall still inserts the bubble.
- Stall: controls, indices, valid and use_imm held. Held rs/rt operands are overwritten with their current forwarded values (refresh), so a producer retiring from MEM/WB during the stall is not lost.
- Forwarding is combinational on outputs, evaluated per source:
  - EX/MEM match when exmem_wr_en=1 and exmem_rd equals the held index → exmem_data.
  - Else MEM/WB match with the same rule → memwb_data.
  - Else the held register value.
  - EX/MEM always wins when both stages match.
- alu_a = forwarded rs.
- alu_b = held imm when use_imm=1, with no forwarding on B in that case; otherwise forwarded rt.
- Forwarding is applied even when ex_valid=0. Harmless, because ex_wr_en=0 suppresses any write.
- No arithmetic is performed here. Widths pass through unchanged, and shift amount is alu_b[3:0] as the ALU interprets it.
- ex_wr_en = ex_valid & held wr_en.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with id_valid=1 → all outputs 0 the cycle after; ex_valid=0.
- Plain load: id_op=4 (ADD), rs_data=0x0123, rt_data=0x0234, no forwarding → next cycle alu_a=0x0123, alu_b=0x0234, alu_op=4.
- Double-hazard priority: rs_idx=2; exmem (wr_en=1, rd=2, data=0xAAAA) and memwb (wr_en=1, rd=2, data=0x5555) → alu_a=0xAAAA. With exmem_wr_en=0 → alu_a=0x5555.
- Immediate path: use_imm=1, imm=0x0008, rt_idx=3, exmem rd=3 data=0xFFFF → alu_b=0x0008, not forwarded.
- Stall refresh: rs_idx=1 loaded. Cycle N: memwb rd=1 data=0x1234 with stall=1. Cycle N+1: memwb_wr_en=0, stall=0 → alu_a still 0x1234.
- Flush during stall: stall=1, flush=1 with valid instruction held → next cycle ex_valid=0, ex_wr_en=0, alu_op=0.
